serial_sub: RTL and testbench
=============================

# serial_sub

Bit-serial N-bit subtractor built around a single full-subtractor stage and a borrow flip-flop. It computes a − b − bin one bit per clock, LSB first, under a start/busy/done handshake. It is the parametrised, sequential successor to the combinational one-bit `full_sub` cell, trading latency for area on wide operands. Results are held stable until the next accepted start.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `start`  input  1: request to begin a subtraction; sampled on the rising edge.
- `a`  input  WIDTH: minuend; sampled on the edge that accepts `start`.
- `b`  input  WIDTH: subtrahend; sampled on the edge that accepts `start`.
- `bin`  input  1: borrow-in to bit 0; sampled on the edge that accepts `start`.
- `busy`  output  1: high while a subtraction is in progress.
- `done`  output  1: single-cycle pulse; `diff`, `bout` and `ovf` are valid from this cycle onward.
- `diff`  output  WIDTH: difference, a − b − bin mod 2^WIDTH.
- `bout`  output  1: borrow-out of the MSB. This is the unsigned underflow flag.
- `ovf`  output  1: two's-complement overflow of a − b − bin.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `start`=1 is accepted.
  - On acceptance, latch `a` and `b` into shift registers sa and sb, load the borrow register br with `bin`, clear bit counter cnt to 0, and go to RUN.
  - `start`=0: stay in IDLE.
- **RUN**, on each edge:
  - d = sa[0] ^ sb[0] ^ br.
  - nb = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - Shift sa and sb right by 1.
  - Shift d into the MSB of the diff register, which shifts right.
  - br ← nb; cnt ← cnt+1.
- **Last RUN bit** (cnt = WIDTH−1):
  - Capture `ovf` ← br ^ nb, i.e. borrow-into-MSB XOR borrow-out-of-MSB.
  - `bout` ← nb.
  - Go to DONE.
- **DONE**: assert `done` for exactly one cycle, then go to IDLE unconditionally.
- **`start` outside IDLE** (RUN or DONE) is ignored. It is not queued, and the latched operands are unaffected.
- **Operand changes**: `a`, `b` and `bin` may change freely after the accepting edge; they have no effect until the next accepted start.
- **Output visibility**
  - `diff` shifts visibly during RUN; its contents are valid only from `done` onward.
  - `diff`, `bout` and `ovf` hold their values from DONE through IDLE until the next accepted start.
  - At the next accepted start, `bout` and `ovf` clear to 0 and `diff` begins shifting.
- **Counter width**: cnt is $clog2(WIDTH)+1 bits; it never wraps within one operation.
- **Derived outputs**: `busy` = (state==RUN); `done` = (state==DONE).

## Timing
- **Reset values**: state=IDLE, `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0; sa, sb, br and cnt are all 0.
- **Reset behaviour**: reset takes effect immediately and asynchronously. It aborts any operation in progress with no `done` pulse, and the block returns to IDLE with all outputs 0.
- **Latency**, for `start` accepted at edge k:
  - `busy`=1 from edge k to edge k+WIDTH.
  - `done`=1 from edge k+WIDTH to edge k+WIDTH+1.
- **Throughput**: the earliest next acceptance is edge k+WIDTH+2 (IDLE sampled after DONE), giving one result per WIDTH+2 cycles at maximum rate.
- **`start` held high continuously**: back-to-back operations run every WIDTH+2 cycles, each using the operands present at its accepting edge.
- **Reset release**: `start` is honoured from the first rising edge on which `rst` is low.

## Test plan
- **Basic subtract**: WIDTH=8, a=0x05, b=0x03, bin=0 → `done` 8 cycles after the accepting edge; `diff`=0x02, `bout`=0, `ovf`=0; `busy` high for exactly 8 cycles.
- **Underflow with borrow-in**: a=0x00, b=0x01, bin=1 → `diff`=0xFE, `bout`=1, `ovf`=0.
- **Overflow and underflow together**:
  - a=0x80, b=0x01, bin=0 → `diff`=0x7F, `bout`=0, `ovf`=1.
  - a=0x7F, b=0xFF, bin=0 → `diff`=0x80, `bout`=1, `ovf`=1.
- **Handshake**:
  - Pulse `start` with new operands at cycles 3 and 7 of RUN, and during DONE → all ignored; the result matches the first operands.
  - Outputs hold for 20 idle cycles after DONE.
  - With `start` held high, `done` pulses every 10 cycles.
- **Reset mid-op**: assert `rst` at cycle 4 of RUN → `busy`, `done`, `diff`, `bout` and `ovf` all go to 0 immediately, with no `done` pulse. The next start then yields a correct result.
- **Exhaustive check**: WIDTH=4, all 512 combinations of a, b and bin, compared against a behavioural model of a−b−bin → `diff`, `bout` and `ovf` match for every case, and every `done` arrives exactly 4 cycles after acceptance.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency: busy for WIDTH cycles after the accepting edge, then a one-cycle done pulse.
// No backpressure: start is only honoured in IDLE; results hold until the next accepted start.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    // Counter carries one spare bit so it can never wrap inside an operation.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             nb;
    logic             last;

    // Single full-subtractor stage working on the current LSBs and the stored borrow.
    assign d    = sa[0] ^ sb[0] ^ br;
    assign nb   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last = (cnt == CW'(WIDTH - 1));

    // Control FSM plus the operand/result shift datapath; busy and done are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
                        bout  <= 1'b0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    diff <= {d, diff[WIDTH-1:1]};
                    br   <= nb;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        // Signed overflow: borrow into the MSB differs from borrow out of it.
                        ovf   <= br ^ nb;
                        bout  <= nb;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: 8-bit directed cases and handshake, 4-bit exhaustive.
// Inputs driven and outputs sampled on the falling edge.
// Every check is an immediate assertion feeding the checks/failures counters.
module tb_serial_sub;

    logic       clk;
    logic       rst;

    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;

    logic       start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;

    int checks;
    int failures;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .bin   (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8),
        .ovf   (ovf8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .bin   (bin4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4),
        .ovf   (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One 8-bit operation at full rate; entered and left on a falling edge in IDLE.
    // With noise set, start is pulsed with junk operands at RUN cycles 3 and 7 and in DONE.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic [7:0] ed, input logic eb,
                       input logic eo, input logic noise);
        start8 = 1'b1; a8 = ta; b8 = tb; bin8 = tbin;
        step();
        start8 = 1'b0; a8 = ~ta; b8 = ~tb; bin8 = ~tbin;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_run"}, {30'd0, busy8, done8}, {30'd0, 1'b1, 1'b0});
            if (noise && (i == 3 || i == 7)) begin
                start8 = 1'b1; a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            step();
        end
        chk({tag, "_donepulse"}, {30'd0, busy8, done8}, {30'd0, 1'b0, 1'b1});
        chk({tag, "_diff"}, {24'd0, diff8}, {24'd0, ed});
        chk({tag, "_bout"}, {31'd0, bout8}, {31'd0, eb});
        chk({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, eo});
        if (noise) begin
            start8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; bin8 = 1'b0;
        end
        step();
        start8 = 1'b0;
        chk({tag, "_after"}, {20'd0, busy8, done8, bout8, ovf8, diff8},
            {20'd0, 1'b0, 1'b0, eb, eo, ed});
    endtask

    // One 4-bit operation; done must land exactly 4 cycles after the accepting edge.
    task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin,
                       input logic [3:0] ed, input logic eb, input logic eo);
        start4 = 1'b1; a4 = ta; b4 = tb; bin4 = tbin;
        step();
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("x4_run", {30'd0, busy4, done4}, {30'd0, 1'b1, 1'b0});
            step();
        end
        chk("x4_result", {24'd0, busy4, done4, bout4, ovf4, diff4},
            {24'd0, 1'b0, 1'b1, eb, eo, ed});
        step();
        chk("x4_after", {30'd0, busy4, done4}, 32'd0);
    endtask

    initial begin
        int sa_i, sb_i, s;
        logic [3:0] ed4;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; bin4 = 1'b0;

        // Reset state of both instances.
        step();
        step();
        chk("rst8", {20'd0, busy8, done8, bout8, ovf8, diff8}, 32'd0);
        chk("rst4", {24'd0, busy4, done4, bout4, ovf4, diff4}, 32'd0);
        rst = 1'b0;

        // Basic, underflow-with-borrow, overflow cases.
        op8("basic",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        op8("under",  8'h00, 8'h01, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0);
        op8("ovf1",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        op8("ovf2",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

        // Start pulses during RUN/DONE are ignored: 0x3C - 0x15 - 1 = 0x26.
        op8("ignore", 8'h3C, 8'h15, 1'b1, 8'h26, 1'b0, 1'b0, 1'b1);

        // Results hold for 20 idle cycles while operands wander.
        for (int i = 0; i < 20; i++) begin
            a8 = 8'(i * 13); b8 = 8'(i * 7); bin8 = i[0];
            step();
            chk("hold", {20'd0, busy8, done8, bout8, ovf8, diff8},
                {20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h26});
        end

        // start held high: done at cycles 8, 18, 28; second and third ops use 0x10-0x01.
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            chk("b2b_done", {31'd0, done8}, {31'd0, (c == 8 || c == 18 || c == 28)});
            if (c == 8)  chk("b2b_diff1", {24'd0, diff8}, 32'h02);
            if (c == 18) chk("b2b_diff2", {24'd0, diff8}, 32'h0F);
            if (c == 28) chk("b2b_diff3", {24'd0, diff8}, 32'h0F);
            if (c == 9) begin
                a8 = 8'h10; b8 = 8'h01;
            end
            if (c == 28) start8 = 1'b0;
        end
        step();
        chk("b2b_idle", {30'd0, busy8, done8}, 32'd0);

        // Reset at RUN cycle 4 clears everything at once.
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_busy", {31'd0, busy8}, 32'd1);
        chk("mid_diffnz", {31'd0, (diff8 != 8'h00)}, 32'd1);
        #2 rst = 1'b1;
        #1 chk("mid_rst", {20'd0, busy8, done8, bout8, ovf8, diff8}, 32'd0);
        @(negedge clk);
        chk("mid_rst_hold", {20'd0, busy8, done8, bout8, ovf8, diff8}, 32'd0);
        rst = 1'b0;
        // Accepted on the first edge after release; its run window covers the aborted op's done slot.
        op8("postrst", 8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1, 1'b0);

        // Exhaustive 4-bit sweep against an arithmetic model.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    s    = ia - ib - ic;
                    ed4  = 4'(s);
                    sa_i = (ia >= 8) ? ia - 16 : ia;
                    sb_i = (ib >= 8) ? ib - 16 : ib;
                    op4(4'(ia), 4'(ib), ic[0], ed4, (s < 0),
                        ((sa_i - sb_i - ic) < -8) || ((sa_i - sb_i - ic) > 7));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
